regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle 3-port register file, for the pipelined MIPS core.
- Adds a per-register busy scoreboard that detects RAW/WAW hazards and gates instruction issue.
- Adds a hard-wired zero register and an outstanding-write counter.
- Sits between decode (issue, read ports A1/A2) and write-back (write port A3).

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth is NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1: 1 hard-wires register 0; 0 makes register 0 an ordinary register.

Ports:
- CLK, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-low.
- A1, in, ADDR_W: read address, port 1.
- A2, in, ADDR_W: read address, port 2.
- RD1, out, DATA_W: read data, port 1 (combinational).
- RD2, out, DATA_W: read data, port 2 (combinational).
- WE3, in, 1: write-back enable.
- A3, in, ADDR_W: write-back address.
- WD3, in, DATA_W: write-back data.
- ISSUE_VALID, in, 1: decode presents an instruction.
- USE1, in, 1: instruction reads A1.
- USE2, in, 1: instruction reads A2.
- DEST_VALID, in, 1: instruction writes a register.
- ISSUE_DEST, in, ADDR_W: destination register of the issuing instruction.
- HAZ1, out, 1: RAW hazard on A1.
- HAZ2, out, 1: RAW hazard on A2.
- ISSUE_READY, out, 1: issue may be accepted this cycle.
- BUSY_CNT, out, ADDR_W+1: number of registers with a pending write.

Behaviour:
- Clock and reset: single clock CLK; rst is synchronous and active-low, sampled on the CLK rising edge only.
- Reset clears every register, every busy bit and BUSY_CNT. After reset: RD1=RD2=0, HAZ1=HAZ2=0, ISSUE_READY=1, BUSY_CNT=0.
- Reset mid-operation discards all pending writes. It has priority over WE3 and issue in the same cycle.
- Reads: RD1=Reg[A1], RD2=Reg[A2], combinational, zero-cycle latency.
- Writes: Reg[A3] <= WD3 at the edge when WE3=1. The new value is visible on RD from the next cycle.
- Zero register (ZERO_REG=1):
  - Writes to register 0 are dropped; it reads 0.
  - Register 0 is never busy.
  - Issue with ISSUE_DEST=0 sets no busy bit and does not change BUSY_CNT.
- Hazards:
  - HAZ1 = USE1 & busy[A1].
  - HAZ2 = USE2 & busy[A2].
  - WAW hazard = DEST_VALID & busy[ISSUE_DEST].
  - ISSUE_READY = !(HAZ1 | HAZ2 | WAW).
  - ISSUE_READY does not depend on ISSUE_VALID.
- Issue acceptance:
  - An issue is accepted when ISSUE_VALID & ISSUE_READY.
  - If DEST_VALID=1 and the destination is nonzero, busy[ISSUE_DEST] is set at the edge.
- Write-back: WE3=1 clears busy[A3] at the edge. WE3 to a non-busy register still writes data and clears nothing.
- Same-register set and clear in one cycle (accepted issue and WE3 to the same register): the set wins, busy stays 1 and BUSY_CNT is unchanged.
- BUSY_CNT:
  - +1 per accepted set of a non-busy register.
  - -1 per clear of a busy register.
  - Both in the same cycle: no change.
  - Never exceeds NUM_REGS. Saturation is unreachable by construction; this is checked by assertion.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When WE3=1 and A3 equals A1 (nonzero when ZERO_REG=1), RD1=WD3 in the same cycle. Same rule for A2/RD2.
  - The hazard terms for that source, and the WAW term when A3==ISSUE_DEST, are computed with busy[A3] treated as 0 that cycle.
  - Net effect: write-back releases a waiting instruction one cycle earlier.
- Undefined:
  - No forwarding.
  - The hazard holds in the write-back cycle and clears on the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W and ADDR_W defaults.
  - ZERO_ADDR constant (0).
  - Function busy_cnt_w(ADDR_W) returning ADDR_W+1.
- One natural sub-module: sb_busy_table, which holds the busy vector, hazard logic and BUSY_CNT.
- The data array and read muxing stay in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 with WE3. Next cycle A1=5 gives RD1=0xDEADBEEF. Pulse rst=0 for one cycle: RD1=0, BUSY_CNT=0.
- Write 0x1234 to r0 with ZERO_REG=1: RD1 stays 0. Issue with ISSUE_DEST=0: BUSY_CNT stays 0.
- Issue DEST=7, then USE1=1, A1=7:
  - HAZ1=1 and ISSUE_READY=0 until WE3 writes r7.
  - Bypass off: HAZ1 drops the cycle after write-back.
  - Bypass on: HAZ1 drops in the write-back cycle and RD1=WD3.
- Issue DEST=9, then issue DEST=9 again: WAW holds ISSUE_READY=0 and BUSY_CNT=1 until r9 is written.
- Same cycle: WE3 to r3 (busy) and accepted issue DEST=3 (bypass on): busy[3] remains 1 and BUSY_CNT is unchanged.
- Issue DEST=1..31 back-to-back: BUSY_CNT=31. Write back all 31 in any order: BUSY_CNT returns to 0 and ISSUE_READY=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned ZERO_ADDR  = 0;

    // Counter width able to hold every register of a 2**addr_w deep file.
    function automatic int unsigned busy_cnt_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/sb_busy_table.sv
// Per-register busy scoreboard: RAW/WAW hazard detection, issue gating and
// outstanding-write counter. Optional macro REGFILE_BYPASS_EN releases the
// write-back target from the hazard view in the write-back cycle itself.
module sb_busy_table
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             a1,
    input  logic [ADDR_W-1:0]             a2,
    input  logic                          use1,
    input  logic                          use2,
    input  logic                          issue_valid,
    input  logic                          dest_valid,
    input  logic [ADDR_W-1:0]             issue_dest,
    input  logic                          we3,
    input  logic [ADDR_W-1:0]             a3,
    output logic                          haz1_c,
    output logic                          haz2_c,
    output logic                          issue_ready_c,
    output logic [busy_cnt_w(ADDR_W)-1:0] busy_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = busy_cnt_w(ADDR_W);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_eff_c;
    logic [CNT_W-1:0]    busy_cnt_q;
    logic [CNT_W-1:0]    busy_cnt_d;
    logic                waw_c;
    logic                set_en_c;
    logic                inc_c;
    logic                dec_c;

    // Busy vector as seen by the hazard checks; forwarding hides the register being written back.
    always_comb begin
        busy_eff_c = busy_q;
`ifdef REGFILE_BYPASS_EN
        if (we3) begin
            busy_eff_c[a3] = 1'b0;
        end
`endif
        haz1_c        = use1 && busy_eff_c[a1];
        haz2_c        = use2 && busy_eff_c[a2];
        waw_c         = dest_valid && busy_eff_c[issue_dest];
        issue_ready_c = !(haz1_c || haz2_c || waw_c);
    end

    // Next busy vector and counter; an accepted set beats a same-cycle clear.
    always_comb begin
        set_en_c = issue_valid && issue_ready_c && dest_valid
                   && !((ZERO_REG != 0) && (issue_dest == ADDR_W'(ZERO_ADDR)));
        busy_d   = busy_q;
        if (we3) begin
            busy_d[a3] = 1'b0;
        end
        if (set_en_c) begin
            busy_d[issue_dest] = 1'b1;
        end
        inc_c      = set_en_c && !busy_q[issue_dest];
        dec_c      = we3 && busy_q[a3] && !(set_en_c && (issue_dest == a3));
        busy_cnt_d = busy_cnt_q + CNT_W'(inc_c) - CNT_W'(dec_c);
    end

    // Scoreboard state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        busy_cnt_q <= CNT_W'(NUM_REGS));

    a_cnt_match: assert property (@(posedge clk) disable iff (!rst_n)
        busy_cnt_q == CNT_W'($countones(busy_q)));

endmodule

// File: rtl/regfile_scoreboard.sv
// Three-port register file with busy scoreboard for the pipelined MIPS core.
// Optional macro REGFILE_BYPASS_EN forwards WD3 to a matching read port in the
// write-back cycle and releases the corresponding hazard one cycle earlier.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             A1,
    input  logic [ADDR_W-1:0]             A2,
    output logic [DATA_W-1:0]             RD1,
    output logic [DATA_W-1:0]             RD2,
    input  logic                          WE3,
    input  logic [ADDR_W-1:0]             A3,
    input  logic [DATA_W-1:0]             WD3,
    input  logic                          ISSUE_VALID,
    input  logic                          USE1,
    input  logic                          USE2,
    input  logic                          DEST_VALID,
    input  logic [ADDR_W-1:0]             ISSUE_DEST,
    output logic                          HAZ1,
    output logic                          HAZ2,
    output logic                          ISSUE_READY,
    output logic [busy_cnt_w(ADDR_W)-1:0] BUSY_CNT
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic              wr_en_c;

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR));
    endfunction

    // Write-back into the data array; the hard-wired zero register ignores writes.
    always_comb begin
        wr_en_c = WE3 && !is_zero_addr(A3);
        mem_d   = mem_q;
        if (wr_en_c) begin
            mem_d[A3] = WD3;
        end
    end

    // Data array with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        RD1 = is_zero_addr(A1) ? '0 : mem_q[A1];
        RD2 = is_zero_addr(A2) ? '0 : mem_q[A2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_c && (A3 == A1)) begin
            RD1 = WD3;
        end
        if (wr_en_c && (A3 == A2)) begin
            RD2 = WD3;
        end
`endif
    end

    sb_busy_table #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk           (CLK),
        .rst_n         (rst),
        .a1            (A1),
        .a2            (A2),
        .use1          (USE1),
        .use2          (USE2),
        .issue_valid   (ISSUE_VALID),
        .dest_valid    (DEST_VALID),
        .issue_dest    (ISSUE_DEST),
        .we3           (WE3),
        .a3            (A3),
        .haz1_c        (HAZ1),
        .haz2_c        (HAZ2),
        .issue_ready_c (ISSUE_READY),
        .busy_cnt      (BUSY_CNT)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard against a behavioural model.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;
    localparam int unsigned CW = 6;
    localparam bit          ZR = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam bit          BYP = 1'b1;
`else
    localparam bit          BYP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          rst;
    logic [AW-1:0] A1, A2, A3, ISSUE_DEST;
    logic [DW-1:0] RD1, RD2, WD3;
    logic          WE3, ISSUE_VALID, USE1, USE2, DEST_VALID;
    logic          HAZ1, HAZ2, ISSUE_READY;
    logic [CW-1:0] BUSY_CNT;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .CLK(CLK), .rst(rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .ISSUE_VALID(ISSUE_VALID),
        .USE1(USE1), .USE2(USE2), .DEST_VALID(DEST_VALID),
        .ISSUE_DEST(ISSUE_DEST), .HAZ1(HAZ1), .HAZ2(HAZ2),
        .ISSUE_READY(ISSUE_READY), .BUSY_CNT(BUSY_CNT)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: architectural register values plus a set of pending destinations.
    logic [DW-1:0] m_reg  [NR];
    bit            m_busy [NR];

    function automatic bit zr(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (zr(a)) return '0;
        if (BYP && WE3 && (A3 == a)) return WD3;
        return m_reg[a];
    endfunction

    function automatic bit m_pending(input logic [AW-1:0] r);
        return m_busy[r] && !(BYP && WE3 && (A3 == r));
    endfunction

    function automatic bit m_h1();
        return USE1 && m_pending(A1);
    endfunction

    function automatic bit m_h2();
        return USE2 && m_pending(A2);
    endfunction

    function automatic bit m_ready();
        return !(m_h1() || m_h2() || (DEST_VALID && m_pending(ISSUE_DEST)));
    endfunction

    function automatic int m_cnt();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return c;
    endfunction

    // Model state update on each rising edge.
    always @(posedge CLK) begin
        bit acc;
        if (!rst) begin
            foreach (m_reg[i]) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            acc = ISSUE_VALID && m_ready();
            if (WE3) begin
                if (!zr(A3)) m_reg[A3] = WD3;
                m_busy[A3] = 1'b0;
            end
            if (acc && DEST_VALID && !zr(ISSUE_DEST)) m_busy[ISSUE_DEST] = 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("rd1", RD1, m_rd(A1));
            chk("rd2", RD2, m_rd(A2));
            chk("haz1", 32'(HAZ1), 32'(m_h1()));
            chk("haz2", 32'(HAZ2), 32'(m_h2()));
            chk("issue_ready", 32'(ISSUE_READY), 32'(m_ready()));
            chk("busy_cnt", 32'(BUSY_CNT), 32'(m_cnt()));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WE3 = 0; A3 = '0; WD3 = '0; ISSUE_VALID = 0; USE1 = 0; USE2 = 0;
        DEST_VALID = 0; ISSUE_DEST = '0; A1 = '0; A2 = '0;
    endtask

    task automatic issue(input logic [AW-1:0] d);
        ISSUE_VALID = 1; DEST_VALID = 1; ISSUE_DEST = d;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        WE3 = 1; A3 = a; WD3 = d;
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        rst = 0;
        idle();
        step();
        step();
        rst = 1;
        cmp_en = 1;

        // Reset state
        A1 = 5; USE1 = 1; DEST_VALID = 1; ISSUE_DEST = 4;
        @(negedge CLK);
        chk("reset rd1", RD1, 32'h0);
        chk("reset busy_cnt", 32'(BUSY_CNT), 32'd0);
        chk("reset ready", 32'(ISSUE_READY), 32'd1);
        chk("reset haz1", 32'(HAZ1), 32'd0);

        // Write r5 then read it back
        idle(); A1 = 5; wb(5, 32'hDEADBEEF);
        step();
        WE3 = 0;
        @(negedge CLK);
        chk("r5 readback", RD1, 32'hDEADBEEF);
        issue(12);
        step();
        idle(); A1 = 5;
        @(negedge CLK);
        chk("cnt after issue", 32'(BUSY_CNT), 32'd1);

        // Reset wins over a same-cycle write and issue
        rst = 0; wb(5, 32'h55); issue(13);
        step();
        rst = 1; idle(); A1 = 5;
        @(negedge CLK);
        chk("rst rd1", RD1, 32'h0);
        chk("rst busy_cnt", 32'(BUSY_CNT), 32'd0);

        // Zero register
        idle(); wb(0, 32'h1234);
        step();
        idle(); A1 = 0;
        @(negedge CLK);
        chk("r0 read", RD1, 32'h0);
        issue(0);
        step();
        idle();
        @(negedge CLK);
        chk("r0 issue cnt", 32'(BUSY_CNT), 32'd0);

        // RAW hazard on r7
        issue(7);
        step();
        idle(); USE1 = 1; A1 = 7;
        @(negedge CLK);
        chk("raw haz1", 32'(HAZ1), 32'd1);
        chk("raw ready", 32'(ISSUE_READY), 32'd0);
        step();
        wb(7, 32'hCAFE0007);
        @(negedge CLK);
        chk("raw haz1 wb cycle", 32'(HAZ1), BYP ? 32'd0 : 32'd1);
        chk("raw rd1 wb cycle", RD1, BYP ? 32'hCAFE0007 : 32'h0);
        step();
        WE3 = 0;
        @(negedge CLK);
        chk("raw haz1 after", 32'(HAZ1), 32'd0);
        chk("raw rd1 after", RD1, 32'hCAFE0007);

        // WAW on r9
        idle(); issue(9);
        step();
        @(negedge CLK);
        chk("waw ready", 32'(ISSUE_READY), 32'd0);
        chk("waw cnt", 32'(BUSY_CNT), 32'd1);
        step();
        @(negedge CLK);
        chk("waw cnt hold", 32'(BUSY_CNT), 32'd1);
        idle(); wb(9, 32'h9);
        step();
        idle();
        @(negedge CLK);
        chk("waw cnt clear", 32'(BUSY_CNT), 32'd0);
        chk("waw ready clear", 32'(ISSUE_READY), 32'd1);

        // Same-cycle set and clear of r3
        issue(3);
        step();
        idle(); wb(3, 32'h3); issue(3);
        @(negedge CLK);
        chk("r3 collide ready", 32'(ISSUE_READY), BYP ? 32'd1 : 32'd0);
        step();
        idle(); DEST_VALID = 1; ISSUE_DEST = 3;
        @(negedge CLK);
        chk("r3 collide cnt", 32'(BUSY_CNT), BYP ? 32'd1 : 32'd0);
        chk("r3 collide waw", 32'(ISSUE_READY), BYP ? 32'd0 : 32'd1);
        idle(); wb(3, 32'h33);
        step();
        idle();

        // Fill every non-zero register then drain
        for (int d = 1; d < 32; d++) begin
            issue(AW'(d));
            step();
        end
        idle(); DEST_VALID = 1; ISSUE_DEST = 31;
        @(negedge CLK);
        chk("full cnt", 32'(BUSY_CNT), 32'd31);
        chk("full ready", 32'(ISSUE_READY), 32'd0);
        idle();
        for (int d = 31; d >= 1; d--) begin
            wb(AW'(d), 32'(d));
            step();
        end
        idle();
        @(negedge CLK);
        chk("drain cnt", 32'(BUSY_CNT), 32'd0);
        chk("drain ready", 32'(ISSUE_READY), 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) != 0);
            A1          = pick();
            A2          = pick();
            USE1        = 1'($urandom_range(0, 1));
            USE2        = 1'($urandom_range(0, 1));
            ISSUE_VALID = ($urandom_range(0, 3) != 0);
            DEST_VALID  = ($urandom_range(0, 3) != 0);
            ISSUE_DEST  = pick();
            WE3         = ($urandom_range(0, 2) == 0);
            A3          = pick();
            WD3         = $urandom;
            step();
        end

        idle();
        step();
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
